// File: rtl/tx_huge_page_rd_req_pkg.sv
// -----------------------------------------------------------------------------
// tx_huge_page_rd_req_pkg
// Purpose : Shared definitions for the huge-page read-request generator:
//           TLP fmt/type codes (same values as the RX-side defines), FSM state
//           encoding, TRN remainder codes and the header-beat builders.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package tx_huge_page_rd_req_pkg;

  // {fmt[1:0], type[4:0]} for memory read requests
  localparam logic [6:0] FMT_TYPE_MRD32 = 7'b00_00000;
  localparam logic [6:0] FMT_TYPE_MRD64 = 7'b01_00000;

  // TRN trem_n codes: all 8 bytes valid, upper 4 bytes valid, no beat
  localparam logic [7:0] TREM_N_FULL  = 8'h00;
  localparam logic [7:0] TREM_N_UPPER = 8'h0F;
  localparam logic [7:0] TREM_N_IDLE  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_H0    = 3'd2,
    ST_H1    = 3'd3,
    ST_DRAIN = 3'd4,
    ST_FREE  = 3'd5
  } state_e;

  // First header beat: DW0 in [63:32], DW1 (requester ID / tag / BEs) in [31:0]
  function automatic logic [63:0] build_h0(input logic        is64,
                                           input logic [9:0]  len_dw,
                                           input logic [15:0] req_id,
                                           input logic [4:0]  tag);
    logic [6:0] fmt_type;
    fmt_type = is64 ? FMT_TYPE_MRD64 : FMT_TYPE_MRD32;
    return {1'b0, fmt_type, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, len_dw,
            req_id, 3'b000, tag, 4'hF, 4'hF};
  endfunction

  // Second header beat: 64-bit address for MRd64, 32-bit address left-justified for MRd32
  function automatic logic [63:0] build_h1(input logic        is64,
                                           input logic [63:0] addr);
    return is64 ? {addr[63:32], addr[31:2], 2'b00}
                : {addr[31:2], 2'b00, 32'h0000_0000};
  endfunction

endpackage

// File: rtl/tx_huge_page_rd_req_if.sv
// -----------------------------------------------------------------------------
// tx_huge_page_rd_req_if
// Purpose : TRN transmit bus (64-bit, active-low framing/handshake).
// Modports: master - drives data/framing, samples trn_tdst_rdy_n
//           slave  - sink side, drives trn_tdst_rdy_n
// -----------------------------------------------------------------------------
interface tx_huge_page_rd_req_if;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tdst_rdy_n;
  logic        trn_tsrc_dsc_n;
  logic        trn_terrfwd_n;

  modport master (
    output trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
           trn_tsrc_dsc_n, trn_terrfwd_n,
    input  trn_tdst_rdy_n
  );

  modport slave (
    input  trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
           trn_tsrc_dsc_n, trn_terrfwd_n,
    output trn_tdst_rdy_n
  );
endinterface

// File: rtl/tx_huge_page_rd_req.sv
// -----------------------------------------------------------------------------
// tx_huge_page_rd_req
// Purpose : Fetches two alternating host huge pages by issuing MRd32/MRd64
//           TLPs of up to MAX_RD_QW qwords on the TRN TX bus, limiting the
//           number of un-completed reads to MAX_OUTSTANDING, and returns each
//           page to the driver with a one-cycle free pulse once every read of
//           it has completed.
// Ports   : trn_clk, reset (sync, active-high)
//           huge_page_addr_1/2, huge_page_qwords_1/2, huge_page_status_1/2 (in)
//           huge_page_free_1/2 (out, pulse)
//           cfg_completer_id (in), cpl_done (in, pulse)
//           trn : TRN TX bus, master side
// -----------------------------------------------------------------------------
module tx_huge_page_rd_req
  import tx_huge_page_rd_req_pkg::*;
#(
  parameter int MAX_RD_QW       = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                 trn_clk,
  input  logic                 reset,
  input  logic [63:0]          huge_page_addr_1,
  input  logic [63:0]          huge_page_addr_2,
  input  logic [31:0]          huge_page_qwords_1,
  input  logic [31:0]          huge_page_qwords_2,
  input  logic                 huge_page_status_1,
  input  logic                 huge_page_status_2,
  output logic                 huge_page_free_1,
  output logic                 huge_page_free_2,
  input  logic [15:0]          cfg_completer_id,
  input  logic                 cpl_done,
  tx_huge_page_rd_req_if.master trn
);

  localparam logic [31:0] MAX_RD_QW_W = 32'(MAX_RD_QW);
  localparam logic [5:0]  MAX_OUT_W   = 6'(MAX_OUTSTANDING);

  state_e      r_state, w_state_nxt;
  logic        r_cur_page2, w_cur_page2_nxt;   // 0 = page 1, 1 = page 2
  logic [4:0]  r_tag, w_tag_nxt;
  logic [5:0]  r_outstanding, w_outstanding_nxt;
  logic [31:0] r_remaining, w_remaining_nxt;
  logic [63:0] r_rd_addr, w_rd_addr_nxt;
  logic        w_accept, w_h1_accept, w_status;
  logic [31:0] w_len_qw, w_len_qw_nxt;

  logic [63:0] r_td, w_td_nxt;
  logic [7:0]  r_trem_n, w_trem_n_nxt;
  logic        r_tsof_n, r_teof_n, r_tsrc_rdy_n, r_free_1, r_free_2;

  function automatic logic [31:0] len_of(input logic [31:0] rem);
    return (rem < MAX_RD_QW_W) ? rem : MAX_RD_QW_W;
  endfunction

  assign w_accept = !r_tsrc_rdy_n && !trn.trn_tdst_rdy_n;
  assign w_status = r_cur_page2 ? huge_page_status_2 : huge_page_status_1;
  assign w_len_qw = len_of(r_remaining);

  // next-state and request bookkeeping
  always_comb begin
    w_state_nxt     = r_state;
    w_cur_page2_nxt = r_cur_page2;
    w_tag_nxt       = r_tag;
    w_remaining_nxt = r_remaining;
    w_rd_addr_nxt   = r_rd_addr;
    w_h1_accept     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_status) begin
          w_rd_addr_nxt   = r_cur_page2 ? huge_page_addr_2 : huge_page_addr_1;
          w_remaining_nxt = r_cur_page2 ? huge_page_qwords_2 : huge_page_qwords_1;
          w_state_nxt     = (w_remaining_nxt == 32'd0) ? ST_FREE : ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (r_outstanding < MAX_OUT_W) w_state_nxt = ST_H0;
        else                           w_state_nxt = ST_ISSUE;
      end
      ST_H0: begin
        if (w_accept) w_state_nxt = ST_H1;
        else          w_state_nxt = ST_H0;
      end
      ST_H1: begin
        if (w_accept) begin
          w_h1_accept     = 1'b1;
          w_rd_addr_nxt   = r_rd_addr + {29'd0, w_len_qw, 3'b000};
          w_remaining_nxt = r_remaining - w_len_qw;
          w_tag_nxt       = r_tag + 5'd1;
          w_state_nxt     = (w_remaining_nxt == 32'd0) ? ST_DRAIN : ST_ISSUE;
        end else begin
          w_state_nxt = ST_H1;
        end
      end
      ST_DRAIN: begin
        if (r_outstanding == 6'd0) w_state_nxt = ST_FREE;
        else                       w_state_nxt = ST_DRAIN;
      end
      ST_FREE: begin
        w_cur_page2_nxt = !r_cur_page2;
        w_state_nxt     = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // outstanding count: simultaneous issue and completion cancel; saturate at 0
  always_comb begin
    w_outstanding_nxt = r_outstanding;
    if (w_h1_accept && !cpl_done) begin
      w_outstanding_nxt = r_outstanding + 6'd1;
    end else if (!w_h1_accept && cpl_done && (r_outstanding != 6'd0)) begin
      w_outstanding_nxt = r_outstanding - 6'd1;
    end else begin
      w_outstanding_nxt = r_outstanding;
    end
  end

  // Beat contents are decoded from the next-state values and registered, so a
  // beat stays constant for as long as the FSM sits in H0/H1 waiting for accept.
  assign w_len_qw_nxt = len_of(w_remaining_nxt);

  // beat data / remainder for the upcoming cycle
  always_comb begin
    w_td_nxt     = 64'd0;
    w_trem_n_nxt = TREM_N_IDLE;
    unique case (w_state_nxt)
      ST_H0: begin
        w_td_nxt     = build_h0(|w_rd_addr_nxt[63:32], 10'(w_len_qw_nxt * 32'd2),
                                cfg_completer_id, w_tag_nxt);
        w_trem_n_nxt = TREM_N_FULL;
      end
      ST_H1: begin
        w_td_nxt     = build_h1(|w_rd_addr_nxt[63:32], w_rd_addr_nxt);
        w_trem_n_nxt = (|w_rd_addr_nxt[63:32]) ? TREM_N_FULL : TREM_N_UPPER;
      end
      default: begin
        w_td_nxt     = 64'd0;
        w_trem_n_nxt = TREM_N_IDLE;
      end
    endcase
  end

  // state and bookkeeping registers
  always_ff @(posedge trn_clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cur_page2   <= 1'b0;
      r_tag         <= 5'd0;
      r_outstanding <= 6'd0;
      r_remaining   <= 32'd0;
      r_rd_addr     <= 64'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_cur_page2   <= w_cur_page2_nxt;
      r_tag         <= w_tag_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_remaining   <= w_remaining_nxt;
      r_rd_addr     <= w_rd_addr_nxt;
    end
  end

  // registered TRN outputs and free pulses
  always_ff @(posedge trn_clk) begin
    if (reset) begin
      r_td         <= 64'd0;
      r_trem_n     <= TREM_N_IDLE;
      r_tsof_n     <= 1'b1;
      r_teof_n     <= 1'b1;
      r_tsrc_rdy_n <= 1'b1;
      r_free_1     <= 1'b0;
      r_free_2     <= 1'b0;
    end else begin
      r_td         <= w_td_nxt;
      r_trem_n     <= w_trem_n_nxt;
      r_tsof_n     <= (w_state_nxt != ST_H0);
      r_teof_n     <= (w_state_nxt != ST_H1);
      r_tsrc_rdy_n <= !((w_state_nxt == ST_H0) || (w_state_nxt == ST_H1));
      r_free_1     <= (w_state_nxt == ST_FREE) && !w_cur_page2_nxt;
      r_free_2     <= (w_state_nxt == ST_FREE) && w_cur_page2_nxt;
    end
  end

  assign trn.trn_td         = r_td;
  assign trn.trn_trem_n     = r_trem_n;
  assign trn.trn_tsof_n     = r_tsof_n;
  assign trn.trn_teof_n     = r_teof_n;
  assign trn.trn_tsrc_rdy_n = r_tsrc_rdy_n;
  assign trn.trn_tsrc_dsc_n = 1'b1;
  assign trn.trn_terrfwd_n  = 1'b1;
  assign huge_page_free_1   = r_free_1;
  assign huge_page_free_2   = r_free_2;

endmodule
